// File: rtl/apb_ram_arbiter_pkg.sv
// Shared types and constants for the two-client APB RAM arbiter.
package apb_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // Maps a client index to its {done1, done0} pulse pattern.
    function automatic logic [1:0] client_onehot(input logic client);
        return (client == CLIENT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_ram_arbiter_rr.sv
// Two-way round-robin grant: combinational winner, preference pointer
// that moves to the other client whenever a grant is accepted.
module apb_rr_arbiter_2
    import apb_ram_arbiter_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);

    logic prefer;

    always_comb begin
        grant = CLIENT0;
        if (req == 2'b11) begin
            grant = prefer;
        end else if (req[1]) begin
            grant = CLIENT1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prefer <= CLIENT0;
        end else if (accept) begin
            prefer <= ~grant;
        end
    end

endmodule

// File: rtl/apb_ram_arbiter.sv
// Two-client APB master sharing one APB RAM slave, round-robin arbitrated.
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_ram_arbiter
    import apb_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_t state;
    logic       granted;
    logic       grant;
    logic       accept;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcount;
`endif

    // The pointer only advances when IDLE actually latches a winner.
    assign accept = (state == IDLE) && (req0 || req1);

    apb_rr_arbiter_2 u_rr (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .req    ({req1, req0}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            granted <= CLIENT0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
`ifdef APB_TIMEOUT_EN
            tcount  <= '0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (accept) begin
                        granted <= grant;
                        PWRITE  <= (grant == CLIENT1) ? we1    : we0;
                        PADDR   <= (grant == CLIENT1) ? addr1  : addr0;
                        PWDATA  <= (grant == CLIENT1) ? wdata1 : wdata0;
                        PSEL    <= 1'b1;
                        state   <= SETUP;
`ifdef APB_TIMEOUT_EN
                        tcount  <= '0;
`endif
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rdata            <= PWRITE ? '0 : PRDATA;
                        err              <= PSLVERR;
                        {done1, done0}   <= client_onehot(granted);
                        PSEL             <= 1'b0;
                        PENABLE          <= 1'b0;
                        state            <= IDLE;
`ifdef APB_TIMEOUT_EN
                    end else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                        rdata            <= '0;
                        err              <= 1'b1;
                        {done1, done0}   <= client_onehot(granted);
                        PSEL             <= 1'b0;
                        PENABLE          <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        tcount           <= tcount + TW'(1);
`endif
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Bench for apb_ram_arbiter: behavioural APB RAM slave plus a completion
// scoreboard; the timeout scenario follows APB_TIMEOUT_EN.
module tb_apb_ram_arbiter;

    typedef struct packed {
        logic        client;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1, err;
    logic [31:0] rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails  = 0;

    logic [31:0] slave_mem [0:1023];
    logic [31:0] model_mem [0:1023];
    int          wait_cnt    = 0;
    int          wait_target = 0;
    bit          slave_hang  = 1'b0;
    bit          inject      = 1'b0;
    logic [9:0]  err_addr    = 10'h3FF;

    apb_ram_arbiter #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .done0   (done0),
        .done1   (done1),
        .rdata   (rdata),
        .err     (err),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = PSEL && PENABLE && !slave_hang && (wait_cnt >= wait_target);
    assign PRDATA  = (PSEL && PENABLE && !PWRITE) ? slave_mem[PADDR] : 32'h0;
    assign PSLVERR = PREADY && inject && !PWRITE && (PADDR == err_addr);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR] <= PWDATA;
        if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (!PRESET && (done0 || done1)) begin
            checks++;
            if (done0 && done1) begin
                fails++;
                $display("[TB] FAIL done_overlap: done0=%b done1=%b, required one-hot", done0, done1);
            end else if (sb.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_done: done0=%b done1=%b with no pending transfer", done0, done1);
            end else begin
                mon_e = sb.pop_front();
                if ({done1, rdata, err} !== {mon_e.client, mon_e.rdata, mon_e.err}) begin
                    fails++;
                    $display("[TB] FAIL completion: client=%0d rdata=%h err=%b, required client=%0d rdata=%h err=%b",
                             done1, rdata, err, mon_e.client, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic do_txn(input bit c, input bit w, input logic [9:0] a,
                          input logic [31:0] d, output bit ok);
        exp_t e;
        int   n;
        @(negedge PCLK);
        e.client = c;
        e.err    = !w && inject && (a == err_addr);
        e.rdata  = w ? 32'h0 : model_mem[a];
        if (w) model_mem[a] = d;
        sb.push_back(e);
        if (!c) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge PCLK);
            n++;
            if ((!c && done0) || (c && done1)) ok = 1;
        end
        if (!c) req0 = 0; else req1 = 0;
    endtask

    task automatic test_reset();
        PRESET = 1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_apb_ctrl: PSEL/PENABLE=%b required 00", {PSEL, PENABLE});
        end
        checks++;
        if ({done0, done1, err, rdata} !== 35'h0) begin
            fails++; $display("[TB] FAIL reset_client_out: done0=%b done1=%b err=%b rdata=%h required all 0", done0, done1, err, rdata);
        end
        checks++;
        if ({PWRITE, PADDR, PWDATA} !== 43'h0) begin
            fails++; $display("[TB] FAIL reset_apb_data: PWRITE=%b PADDR=%h PWDATA=%h required 0", PWRITE, PADDR, PWDATA);
        end
        PRESET = 0;
        repeat (2) @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b0) begin
            fails++; $display("[TB] FAIL idle_no_req: PSEL=%b required 0", PSEL);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic w;
        @(negedge PCLK);
        for (int k = 0; k < 2; k++) begin
            w        = (k == 0);
            e.client = 1'b0;
            e.err    = 1'b0;
            if (w) begin e.rdata = 32'h0; model_mem[10'h05A] = 32'hDEADBEEF; end
            else   e.rdata = model_mem[10'h05A];
            sb.push_back(e);
            req0 = 1; we0 = w; addr0 = 10'h05A; wdata0 = 32'hDEADBEEF;
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, w, 10'h05A, 32'hDEADBEEF}) begin
                fails++; $display("[TB] FAIL setup_phase: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h required 1 0 %b 05a deadbeef",
                                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, w);
            end
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE, done0} !== 3'b110) begin
                fails++; $display("[TB] FAIL access_phase: PSEL/PENABLE/done0=%b required 110", {PSEL, PENABLE, done0});
            end
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE, done0} !== 3'b001) begin
                fails++; $display("[TB] FAIL done_latency: PSEL/PENABLE/done0=%b required 001", {PSEL, PENABLE, done0});
            end
        end
        req0 = 0;
    endtask

    task automatic test_simultaneous();
        logic        w [2];
        logic [9:0]  a0 [2];
        logic [9:0]  a1 [2];
        logic [31:0] d0, d1;
        int          i0, i1, n;
        exp_t        e;
        w[0] = 1; w[1] = 0;
        a0[0] = 10'h100; a0[1] = 10'h100; d0 = 32'h11110000;
        a1[0] = 10'h200; a1[1] = 10'h200; d1 = 32'h22220000;
        @(negedge PCLK);
        PRESET = 1;
        for (int k = 0; k < 2; k++) begin
            e.err = 0;
            e.client = 0; e.rdata = w[k] ? 32'h0 : model_mem[a0[k]];
            if (w[k]) model_mem[a0[k]] = d0;
            sb.push_back(e);
            e.client = 1; e.rdata = w[k] ? 32'h0 : model_mem[a1[k]];
            if (w[k]) model_mem[a1[k]] = d1;
            sb.push_back(e);
        end
        i0 = 0; i1 = 0; n = 0;
        req0 = 1; we0 = w[0]; addr0 = a0[0]; wdata0 = d0;
        req1 = 1; we1 = w[0]; addr1 = a1[0]; wdata1 = d1;
        @(negedge PCLK);
        PRESET = 0;
        while ((i0 < 2 || i1 < 2) && n < 100) begin
            @(negedge PCLK);
            n++;
            if (done0) begin
                i0++;
                if (i0 < 2) begin we0 = w[i0]; addr0 = a0[i0]; end else req0 = 0;
            end
            if (done1) begin
                i1++;
                if (i1 < 2) begin we1 = w[i1]; addr1 = a1[i1]; end else req1 = 0;
            end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (i0 != 2 || i1 != 2) begin
            fails++; $display("[TB] FAIL simultaneous_progress: done counts %0d/%0d required 2/2", i0, i1);
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        bit   ready_seen, ok;
        int   waits, n;
        wait_target = 3;
        @(negedge PCLK);
        e.client = 1; e.rdata = 32'h0; e.err = 0;
        model_mem[10'h123] = 32'hCAFEF00D;
        sb.push_back(e);
        req1 = 1; we1 = 1; addr1 = 10'h123; wdata1 = 32'hCAFEF00D;
        @(negedge PCLK);
        ready_seen = 0; waits = 0; n = 0;
        while (!ready_seen && n < 20) begin
            @(negedge PCLK);
            n++;
            checks++;
            if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, done1} !== {3'b111, 10'h123, 32'hCAFEF00D, 1'b0}) begin
                fails++; $display("[TB] FAIL access_stable: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h done1=%b required 1 1 1 123 cafef00d 0",
                                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, done1);
            end
            if (PREADY) ready_seen = 1; else waits++;
        end
        checks++;
        if (!ready_seen || waits != 3) begin
            fails++; $display("[TB] FAIL wait_count: waits=%0d ready=%b required 3 and 1", waits, ready_seen);
        end
        @(negedge PCLK);
        checks++;
        if (done1 !== 1'b1) begin
            fails++; $display("[TB] FAIL done_after_ready: done1=%b required 1", done1);
        end
        req1 = 0;
        do_txn(1, 0, 10'h123, 32'h0, ok);
        checks++;
        if (!ok) begin
            fails++; $display("[TB] FAIL wait_read_timeout: done1 seen=%b required 1", ok);
        end
        wait_target = 0;
    endtask

    task automatic test_slave_error();
        bit ok0, ok1, ok2;
        inject   = 1;
        err_addr = 10'h3FF;
        do_txn(0, 1, 10'h3FF, 32'h0BADF00D, ok0);
        do_txn(1, 0, 10'h3FF, 32'h0, ok1);
        @(negedge PCLK);
        checks++;
        if ({err, done1, rdata} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
            fails++; $display("[TB] FAIL err_hold: err=%b done1=%b rdata=%h required 1 0 0badf00d", err, done1, rdata);
        end
        do_txn(1, 0, 10'h05A, 32'h0, ok2);
        checks++;
        if (err !== 1'b0) begin
            fails++; $display("[TB] FAIL err_clears: err=%b required 0", err);
        end
        checks++;
        if (!(ok0 && ok1 && ok2)) begin
            fails++; $display("[TB] FAIL error_seq_timeout: completions %b%b%b required 111", ok0, ok1, ok2);
        end
        inject = 0;
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        bit   reached, got0, got1;
        int   n;
        slave_hang = 1;
        @(negedge PCLK);
        req0 = 1; we0 = 1; addr0 = 10'h0AA; wdata0 = 32'h55555555;
        reached = 0; n = 0;
        while (!reached && n < 10) begin
            @(negedge PCLK);
            n++;
            if (PENABLE) reached = 1;
        end
        checks++;
        if (!reached) begin
            fails++; $display("[TB] FAIL reach_access: PENABLE seen=%b required 1", reached);
        end
        #2 PRESET = 1;
        #1;
        checks++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            fails++; $display("[TB] FAIL async_drop: PSEL/PENABLE=%b required 00", {PSEL, PENABLE});
        end
        slave_hang = 0;
        e.err = 0;
        e.client = 0; e.rdata = model_mem[10'h05A]; sb.push_back(e);
        e.client = 1; e.rdata = model_mem[10'h123]; sb.push_back(e);
        req0 = 1; we0 = 0; addr0 = 10'h05A;
        req1 = 1; we1 = 0; addr1 = 10'h123;
        @(negedge PCLK);
        checks++;
        if ({done0, done1} !== 2'b00) begin
            fails++; $display("[TB] FAIL no_done_in_reset: done0/done1=%b required 00", {done0, done1});
        end
        PRESET = 0;
        got0 = 0; got1 = 0; n = 0;
        while (!(got0 && got1) && n < 40) begin
            @(negedge PCLK);
            n++;
            if (done0) begin got0 = 1; req0 = 0; end
            if (done1) begin got1 = 1; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (!(got0 && got1)) begin
            fails++; $display("[TB] FAIL post_reset_service: done0 seen=%b done1 seen=%b required 1 1", got0, got1);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        bit   seen;
        int   acc, n;
        slave_hang = 1;
        @(negedge PCLK);
        e.client = 0; e.rdata = 32'h0; e.err = 1;
        sb.push_back(e);
        req0 = 1; we0 = 0; addr0 = 10'h05A;
        seen = 0; acc = 0; n = 0;
        while (!seen && n < 60) begin
            @(negedge PCLK);
            n++;
            if (done0) seen = 1;
            else if (PENABLE) acc++;
        end
        req0 = 0;
        slave_hang = 0;
        checks++;
        if (!seen || acc != 16) begin
            fails++; $display("[TB] FAIL timeout_cycles: access cycles=%0d done0 seen=%b required 16 and 1", acc, seen);
        end
        checks++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            fails++; $display("[TB] FAIL timeout_idle: PSEL/PENABLE=%b required 00", {PSEL, PENABLE});
        end
    endtask
`else
    task automatic test_timeout();
        exp_t e;
        bit   early, seen;
        int   n;
        slave_hang = 1;
        @(negedge PCLK);
        e.client = 0; e.rdata = model_mem[10'h05A]; e.err = 0;
        sb.push_back(e);
        req0 = 1; we0 = 0; addr0 = 10'h05A;
        early = 0;
        repeat (40) begin
            @(negedge PCLK);
            if (done0) early = 1;
        end
        checks++;
        if (early || {PSEL, PENABLE} !== 2'b11) begin
            fails++; $display("[TB] FAIL no_timeout_wait: early done=%b PSEL/PENABLE=%b required 0 and 11", early, {PSEL, PENABLE});
        end
        slave_hang = 0;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge PCLK);
            n++;
            if (done0) seen = 1;
        end
        req0 = 0;
        checks++;
        if (!seen) begin
            fails++; $display("[TB] FAIL late_ready_done: done0 seen=%b required 1", seen);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting apb_ram_arbiter bench");
        test_reset();
        test_write_read();
        test_simultaneous();
        test_wait_states();
        test_slave_error();
        test_reset_mid_access();
        test_timeout();
        repeat (3) @(negedge PCLK);
        checks++;
        if (sb.size() != 0) begin
            fails++; $display("[TB] FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_ram_arbiter.md
Name: apb_ram_arbiter

Overview:
- Two-requester APB master that shares the single APB RAM slave (apb_ram_interface) between two on-chip clients.
- Each client issues simple req/done transactions.
- The block arbitrates round-robin and sequences the APB IDLE→SETUP→ACCESS phases.
- It waits on PREADY and returns read data and error status to the granted client.

Parameters:
- DATA_WIDTH, 32, width of data buses (client and APB).
- ADDR_WIDTH, 10, width of address buses (client and APB).
- TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  system clock, all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req0  in  1  client 0 transaction request; held until done0.
- we0  in  1  client 0 write (1) / read (0).
- addr0  in  ADDR_WIDTH  client 0 address.
- wdata0  in  DATA_WIDTH  client 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_WIDTH/DATA_WIDTH  client 1 equivalents.
- done0  out  1  one-cycle completion pulse, client 0.
- done1  out  1  one-cycle completion pulse, client 1.
- rdata  out  DATA_WIDTH  read data; valid in the cycle done0/done1 is high.
- err  out  1  slave error or timeout; valid with done.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clocking and reset:
  - One clock (PCLK); reset PRESET is asynchronous, active-high.
  - Reset forces all outputs to 0, FSM to IDLE and the round-robin pointer to "client 0 preferred".
  - Reset mid-transfer drops PSEL/PENABLE immediately; the in-flight transaction is lost and no done is issued.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req is high, pick a winner and latch its we/addr/wdata into PWRITE/PADDR/PWDATA.
  - Drive PSEL=1 and go to SETUP.
- Arbitration:
  - Only one req high: that client wins.
  - Both high: the preferred client wins, and the pointer then prefers the other client.
  - A single-client win also flips preference to the other client.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then PENABLE=1 and go to ACCESS.
- ACCESS:
  - Hold PSEL=PENABLE=1 and the address/data/direction stable until PREADY=1 is sampled.
  - On PREADY: register rdata=PRDATA (reads only; writes return 0) and err=PSLVERR.
  - In the same step, pulse done for the granted client next cycle, drop PSEL/PENABLE and return to IDLE.
- Latency and throughput:
  - Latency with zero-wait slave: req sampled at edge N → SETUP after N → ACCESS after N+1 → done high after N+2.
  - Minimum 3 cycles per transfer, plus 1 IDLE cycle between back-to-back transfers.
- Client contract:
  - Hold req and request fields until done.
  - Req changes after the grant latch are ignored for the current transfer.
  - A client that keeps req high after done is re-arbitrated in the next IDLE.
- done0 and done1 are never high together; rdata/err hold their value until the next done.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If PREADY has not been seen after TIMEOUT_CYCLES ACCESS cycles, abort: drop PSEL/PENABLE, pulse done with err=1, rdata=0, return to IDLE.
  - The counter clears on entry to SETUP and on reset.
- Undefined: no counter; ACCESS waits on PREADY indefinitely.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
  - Client index constants.
  - Default DATA_WIDTH/ADDR_WIDTH.
- One sub-module is natural: apb_rr_arbiter_2, the 2-way round-robin grant logic with pointer register and update-on-accept input.
- The FSM and APB drive stay in the top module.

Test Plan:
- Single write then read: req0 we0=1 addr0=10'h05A wdata0=32'hDEADBEEF, then read 10'h05A → PSEL/PENABLE phase order correct, done0 after 3 cycles, rdata=32'hDEADBEEF, err=0.
- Simultaneous requests: req0 and req1 both high continuously out of reset → grants alternate 0,1,0,1; each done has the correct client's data; done0 and done1 never overlap.
- Wait states: slave holds PREADY=0 for 3 ACCESS cycles → PADDR/PWDATA/PWRITE stable throughout, done asserted exactly one cycle after PREADY=1.
- Slave error: PSLVERR=1 with PREADY on a read to 10'h3FF → done1 with err=1; the next transfer reports err=0.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 → PSEL/PENABLE drop asynchronously, no done; after release, a pending req1 is served first only if req0 is low (pointer back to client 0 preferred).
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY tied low → abort after 16 ACCESS cycles with done, err=1, rdata=0, FSM back in IDLE.
